// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the serial bus slave ports.
//               - rx_state_e   : receive-port state encoding
//               - c_INSTR_*    : instruction encodings {active, is_read}
//               - c_*_LEN/SIZE : default field widths
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_ADDRESS_LEN = 12;
    localparam int c_WORD_SIZE   = 8;
    localparam int c_BURST_SIZE  = 12;

    localparam logic [1:0] c_INSTR_WRITE = 2'b10;
    localparam logic [1:0] c_INSTR_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_STALL  = 3'd3,
        ST_DONE   = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : LSB-first serial-to-parallel converter with a bit counter.
//               Once WIDTH bits have been taken, further shifts are ignored
//               until the counter is cleared.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               clear        - synchronous counter re-arm
//               shift_en     - accept the serial bit this cycle
//               serial       - serial input bit
//               parallel     - assembled value including this cycle's bit
//               count        - number of bits held
//               done         - the bit taken this cycle completes the field
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         shift_en,
    input  logic                         serial,
    output logic [WIDTH-1:0]             parallel,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         done
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_full;
    logic               w_take;

    // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = serial;
        end else begin : g_multi
            assign w_shifted = {serial, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_full   = (r_count == c_CNT_W'(WIDTH));
    assign w_take   = shift_en && !w_full;
    assign done     = w_take && (r_count == c_CNT_W'(WIDTH - 1));
    assign count    = r_count;
    // Look-ahead value lets the parent capture a field on its final bit.
    assign parallel = w_take ? w_shifted : r_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_shift <= '0;
        end else begin
            if (w_take) begin
                r_shift <= w_shifted;
            end
            if (clear) begin
                r_count <= '0;
            end else if (w_take) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/slave_in_port.sv
`default_nettype none
// ============================================================================
// Module      : slave_in_port
// Description : Receive side of a slave bus port. Deserializes the serial
//               address, burst count and write-data streams under the
//               master_valid/slave_ready handshake; presents write words to
//               the core with incrementing addresses, or a read header.
// Ports       : clk, reset             - clock, async active-high reset
//               selected               - decoder routed master to this slave
//               write_en, read_en      - transaction type
//               master_valid           - rx_* bits valid
//               rx_address/burst/data  - serial streams, LSB first
//               core_ready             - core can take a word
//               slave_ready            - port accepts a bit this cycle
//               address, data          - word address / assembled word
//               burst_num              - received burst count
//               word_valid, read_req   - one-cycle strobes
//               rx_done                - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module slave_in_port
    import bus_pkg::*;
#(
    parameter int ADDRESS_LEN = c_ADDRESS_LEN,
    parameter int WORD_SIZE   = c_WORD_SIZE,
    parameter int BURST_SIZE  = c_BURST_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   selected,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic                   master_valid,
    input  logic                   rx_address,
    input  logic                   rx_burst_num,
    input  logic                   rx_data,
    input  logic                   core_ready,
    output logic                   slave_ready,
    output logic [ADDRESS_LEN-1:0] address,
    output logic [WORD_SIZE-1:0]   data,
    output logic [BURST_SIZE-1:0]  burst_num,
    output logic                   word_valid,
    output logic                   read_req,
    output logic                   rx_done
);

    localparam int c_ACNT_W = $clog2(ADDRESS_LEN + 1);
    localparam int c_BCNT_W = $clog2(BURST_SIZE + 1);
    localparam int c_DCNT_W = $clog2(WORD_SIZE + 1);

    rx_state_e              r_state;
    logic                   r_is_write;
    logic [ADDRESS_LEN-1:0] r_base;
    logic [BURST_SIZE-1:0]  r_index;
    logic [BURST_SIZE-1:0]  r_last;

    logic [1:0]             w_instr;
    logic                   w_hdr_shift;
    logic                   w_data_shift;
    logic                   w_hdr_clear;
    logic                   w_data_clear;
    logic                   w_hdr_end;
    logic [ADDRESS_LEN-1:0] w_addr_val;
    logic [BURST_SIZE-1:0]  w_burst_val;
    logic [WORD_SIZE-1:0]   w_data_val;
    logic [c_ACNT_W-1:0]    w_addr_cnt;
    logic [c_BCNT_W-1:0]    w_burst_cnt;
    logic [c_DCNT_W-1:0]    w_data_cnt;
    logic                   w_addr_done;
    logic                   w_burst_done;
    logic                   w_data_done;
    logic                   w_addr_full;
    logic                   w_burst_full;

    // Both enables high folds to an inactive code, keeping the port idle.
    assign w_instr = {write_en ^ read_en, read_en};

    // Combinational so the core can throttle the very next bit.
    assign slave_ready  = (r_state == ST_HEADER) ||
                          ((r_state == ST_DATA) && core_ready);
    assign w_hdr_shift  = (r_state == ST_HEADER) && master_valid && slave_ready;
    assign w_data_shift = (r_state == ST_DATA) && master_valid && slave_ready;
    assign w_hdr_clear  = (r_state == ST_IDLE);
    // Re-arm on the last bit so the next word can start in the strobe cycle.
    assign w_data_clear = (r_state == ST_IDLE) || w_data_done;

    assign w_addr_full  = (w_addr_cnt == c_ACNT_W'(ADDRESS_LEN));
    assign w_burst_full = (w_burst_cnt == c_BCNT_W'(BURST_SIZE));
    // The header ends when the longer field takes its final bit.
    assign w_hdr_end    = w_hdr_shift && (w_addr_full || w_addr_done) &&
                          (w_burst_full || w_burst_done);

    serial_deserializer #(.WIDTH(ADDRESS_LEN)) u_addr (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_hdr_clear),
        .shift_en (w_hdr_shift),
        .serial   (rx_address),
        .parallel (w_addr_val),
        .count    (w_addr_cnt),
        .done     (w_addr_done)
    );

    serial_deserializer #(.WIDTH(BURST_SIZE)) u_burst (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_hdr_clear),
        .shift_en (w_hdr_shift),
        .serial   (rx_burst_num),
        .parallel (w_burst_val),
        .count    (w_burst_cnt),
        .done     (w_burst_done)
    );

    serial_deserializer #(.WIDTH(WORD_SIZE)) u_data (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_data_clear),
        .shift_en (w_data_shift),
        .serial   (rx_data),
        .parallel (w_data_val),
        .count    (w_data_cnt),
        .done     (w_data_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_is_write <= 1'b0;
            r_base     <= '0;
            r_index    <= '0;
            r_last     <= '0;
            address    <= '0;
            data       <= '0;
            burst_num  <= '0;
            word_valid <= 1'b0;
            read_req   <= 1'b0;
            rx_done    <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            read_req   <= 1'b0;
            rx_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (selected && (w_instr == c_INSTR_WRITE ||
                                     w_instr == c_INSTR_READ)) begin
                        r_is_write <= (w_instr == c_INSTR_WRITE);
                        r_state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (!selected) begin
                        r_state <= ST_IDLE;
                    end else if (w_hdr_end) begin
                        r_base    <= w_addr_val;
                        burst_num <= w_burst_val;
                        r_index   <= '0;
                        // A zero burst count still moves one word.
                        r_last    <= (w_burst_val == '0) ? '0 : w_burst_val - 1'b1;
                        if (r_is_write) begin
                            r_state <= ST_DATA;
                        end else begin
                            address  <= w_addr_val;
                            read_req <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (!selected) begin
                        r_state <= ST_IDLE;
                    end else if (w_data_done) begin
                        word_valid <= 1'b1;
                        data       <= w_data_val;
                        address    <= r_base + ADDRESS_LEN'(r_index);
                        if (r_index == r_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else if (!core_ready && (w_data_cnt == '0)) begin
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!selected) begin
                        r_state <= ST_IDLE;
                    end else if (core_ready) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    rx_done <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/slave_in_port.md
# slave_in_port

Receive side of a slave's bus port, directly downstream of the master port. Deserializes the bit-serial address, burst count and write-data streams driven by the master, gated by the master_valid/slave_ready handshake. For writes it presents each assembled word to the slave core with an incrementing address. For reads it delivers the request header to the slave's return path.

## Interface
- ADDRESS_LEN, 12, serial address length in bits
- WORD_SIZE, 8, data word length in bits
- BURST_SIZE, 12, burst count field length in bits

- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- selected  input  1  bus decoder has routed the current master to this slave
- write_en  input  1  write transaction, held for the whole transaction
- read_en  input  1  read transaction, held for the whole transaction
- master_valid  input  1  serial bits on rx_* lines are valid this cycle
- rx_address  input  1  serial address, LSB first
- rx_burst_num  input  1  serial burst count, LSB first
- rx_data  input  1  serial write data, LSB first, words back to back
- core_ready  input  1  slave core can accept a word
- slave_ready  output  1  port accepts a bit this cycle
- address  output  ADDRESS_LEN  word address (base + word index)
- data  output  WORD_SIZE  assembled write word
- burst_num  output  BURST_SIZE  received burst count
- word_valid  output  1  one-cycle write strobe for data/address
- read_req  output  1  one-cycle read header strobe for address/burst_num
- rx_done  output  1  one-cycle transaction-complete pulse

## Operation
- A bit is accepted only on a cycle with master_valid && slave_ready. No other cycle shifts any register.
- States: IDLE, HEADER, DATA, STALL, DONE.
- IDLE: slave_ready=0. If selected && (write_en XOR read_en), go to HEADER. Both enables high, or both low, keeps the port in IDLE.
- HEADER: slave_ready=1. The address and burst streams shift in parallel. Address is complete after ADDRESS_LEN accepted bits; burst is complete after BURST_SIZE accepted bits. Header ends at max(ADDRESS_LEN, BURST_SIZE) accepted bits. Bits beyond a field's length are ignored.
- Burst count: burst value N means N words; N=0 is treated as 1.
- End of header, read: pulse read_req for one cycle with address and burst_num valid, then go to DONE.
- End of header, write: go to DATA with word index 0.
- DATA: slave_ready = core_ready. After WORD_SIZE accepted bits:
  - word_valid pulses the next cycle, with data = assembled word and address = base + index, modulo 2^ADDRESS_LEN (wraps, no error).
  - index increments.
  - After the last word, go to DONE.
- STALL: entered from DATA when core_ready=0 at a word boundary. slave_ready=0. Return to DATA when core_ready=1.
- DONE: rx_done pulses one cycle, slave_ready=0, then go to IDLE.
- Abort: selected falling in HEADER, DATA or STALL goes to IDLE the next cycle. No word_valid for the partial word, no read_req, no rx_done.
- Reset values: slave_ready, word_valid, read_req and rx_done are 0; address, data and burst_num are all-zero; state is IDLE. Reset mid-transaction discards everything.

## Timing
- IDLE to HEADER takes 1 cycle. slave_ready rises the cycle after selected is seen.
- Header latency equals max(ADDRESS_LEN, BURST_SIZE) handshake cycles. read_req is asserted the cycle after the last header bit.
- word_valid is asserted the cycle after the last bit of each word. The first bit of the next word may be accepted in that same cycle.
- rx_done is asserted the cycle after the final word_valid (write) or read_req (read).
- address, data and burst_num hold their values between strobes.
- Minimum write transaction, burst 1, defaults: 1 + 12 + 8 + 1 + 1 = 23 cycles from selected to rx_done.

## Structure
- bus_pkg holds:
  - the state enum for slave_in_port
  - the shared instruction encodings (10 = write, 11 = read)
  - default ADDRESS_LEN, WORD_SIZE and BURST_SIZE constants
- Sub-module serial_deserializer #(WIDTH): shift_en input, serial input, parallel output, bit counter, done pulse. It is instantiated three times (address, burst, data). The data instance is re-armed per word.

## Test plan
- Write, address 0x123, burst 3, words A5, 3C, FF, core_ready=1 → word_valid at addresses 0x123, 0x124, 0x125 with those data; one rx_done; slave_ready low after.
- Read, address 0x0F0, burst 5 → single read_req with address=0x0F0 and burst_num=5, rx_done the next cycle, no word_valid.
- Write at address 0xFFF with burst 2, and burst 0 → second word at 0x000; burst 0 gives exactly one word_valid.
- core_ready low for 4 cycles after the first word of a burst-2 write, with master_valid stuttering → slave_ready=0 for 4 cycles, no bit lost, second word correct.
- selected dropped mid-word, then reset asserted mid-header → no strobe, no rx_done; all outputs zero; IDLE; the next transaction completes normally.
